// File: rtl/dcm_seq_pkg.sv
// Shared definitions for the DCM lock sequencer.
//   dcm_state_e  : sequencer state encoding
//   DEF_*        : default timing / retry parameters
//   max3()       : largest of three ints, used to size the shared counter
package dcm_seq_pkg;

   typedef enum logic [2:0] {
      RESET_DCM = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } dcm_state_e;

   localparam int DEF_RST_CYCLES   = 8;
   localparam int DEF_LOCK_TIMEOUT = 4096;
   localparam int DEF_RELEASE_DLY  = 16;
   localparam int DEF_MAX_RETRY    = 3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/dcm_lock_sequencer_if.sv
// DCM-side and downstream-reset signals of the lock sequencer.
//   locked     : DCM lock status (asynchronous)
//   dcm_reset  : DCM reset, active high
//   sys_reset  : downstream reset, active high
//   ready      : sequencer in RUN
//   fault      : sequencer in FAULT
//   lock_lost  : one-cycle pulse on lock loss in RUN
//   retry_cnt  : failed attempts since last RUN
// MAX_RETRY must match the value given to the sequencer instance.
interface dcm_lock_sequencer_if #(
   parameter int MAX_RETRY = dcm_seq_pkg::DEF_MAX_RETRY
);
   localparam int RW = $clog2(MAX_RETRY + 1);

   logic          locked;
   logic          dcm_reset;
   logic          sys_reset;
   logic          ready;
   logic          fault;
   logic          lock_lost;
   logic [RW-1:0] retry_cnt;

   modport master (
      input  locked,
      output dcm_reset, sys_reset, ready, fault, lock_lost, retry_cnt
   );

   modport slave (
      output locked,
      input  dcm_reset, sys_reset, ready, fault, lock_lost, retry_cnt
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output resets to 0
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/dcm_lock_sequencer.sv
// DCM power-up / lock-loss sequencer. Holds the DCM in reset, waits for lock
// with timeout and bounded retries, qualifies a stable lock, then releases
// the downstream reset.
//   clkin   : input clock (same net as DCM clkin)
//   reset_n : asynchronous active-low reset
//   bus     : dcm_lock_sequencer_if.master (locked in; resets/status out)
// Optional build macro DCM_SEQ_FAULT_REARM_EN: FAULT re-arms after
// LOCK_TIMEOUT cycles instead of being terminal.
//
// state     | meaning
// RESET_DCM | dcm_reset held high for RST_CYCLES cycles
// WAIT_LOCK | DCM running, waiting for locked_s (LOCK_TIMEOUT limit)
// SETTLE    | locked_s must stay high for RELEASE_DLY cycles
// RUN       | sys_reset released, ready high
// FAULT     | retries exhausted, DCM and system held in reset
module dcm_lock_sequencer
   import dcm_seq_pkg::*;
#(
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int RELEASE_DLY  = DEF_RELEASE_DLY,
   parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
   input  logic                  clkin,
   input  logic                  reset_n,
   dcm_lock_sequencer_if.master  bus
);

   localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, RELEASE_DLY)) + 1;
   localparam int RW    = $clog2(MAX_RETRY + 1);

   // Terminal counts are one less than the cycle counts because the
   // counter is 0 on the first cycle in a state.
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DLY - 1);
   localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

   dcm_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic             locked_s;
   logic             fail;
   logic             lost_d;
   logic             dcm_reset_q, sys_reset_q, ready_q, fault_q, lock_lost_q;

   sync_2ff u_lock_sync (
      .clk   (clkin),
      .rst_n (reset_n),
      .d     (bus.locked),
      .q     (locked_s)
   );

   always_comb begin
      state_d = state_q;
      fail    = 1'b0;
      lost_d  = 1'b0;
      retry_d = retry_q;

      case (state_q)
         RESET_DCM: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         // Lock wins over a timeout on the same cycle.
         WAIT_LOCK: begin
            if (locked_s)              state_d = SETTLE;
            else if (cnt_q == TO_LAST) fail    = 1'b1;
         end
         SETTLE: begin
            if (!locked_s)              fail    = 1'b1;
            else if (cnt_q == REL_LAST) state_d = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_d = RESET_DCM;
               lost_d  = 1'b1;
            end
         end
         FAULT: begin
`ifdef DCM_SEQ_FAULT_REARM_EN
            if (cnt_q == TO_LAST) begin
               state_d = RESET_DCM;
               retry_d = '0;
            end
`else
            state_d = FAULT;
`endif
         end
         default: state_d = RESET_DCM;
      endcase

      if (fail) begin
         if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
         end else begin
            state_d = RESET_DCM;
            retry_d = retry_q + 1'b1;
         end
      end

      if (state_d == RUN && state_q != RUN) retry_d = '0;

      cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RESET_DCM;
         cnt_q       <= '0;
         retry_q     <= '0;
         dcm_reset_q <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         dcm_reset_q <= (state_d == RESET_DCM) || (state_d == FAULT);
         sys_reset_q <= (state_d != RUN);
         ready_q     <= (state_d == RUN);
         fault_q     <= (state_d == FAULT);
         lock_lost_q <= lost_d;
      end
   end

   assign bus.dcm_reset = dcm_reset_q;
   assign bus.sys_reset = sys_reset_q;
   assign bus.ready     = ready_q;
   assign bus.fault     = fault_q;
   assign bus.lock_lost = lock_lost_q;
   assign bus.retry_cnt = retry_q;

endmodule

// File: doc/dcm_lock_sequencer.md
# dcm_lock_sequencer

Sequences the DCM clocking block at power-up and after lock loss. Holds the DCM in reset for a minimum number of input-clock cycles, waits for `locked` with a bounded timeout and limited retries, and qualifies a stable lock before releasing system reset. It sits between the board reset and the DCM `reset`/`locked` pins, and drives the active-high reset for all logic on the DCM output clocks.

## Interface
- `RST_CYCLES`, 8: cycles `dcm_reset` is held high per attempt (DCM minimum is 3).
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT_LOCK before the attempt fails.
- `RELEASE_DLY`, 16: cycles `locked` must stay high before `sys_reset` is released.
- `MAX_RETRY`, 3: failed attempts tolerated before FAULT.
- `clkin` in 1: input clock, same net as the DCM `clkin`.
- `reset_n` in 1: asynchronous, active-low reset.
- `locked` in 1: DCM lock status, asynchronous to `clkin`.
- `dcm_reset` out 1: drives DCM `reset`, active high.
- `sys_reset` out 1: downstream reset, active high.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `lock_lost` out 1: one-cycle pulse when lock drops in RUN.
- `retry_cnt` out `$clog2(MAX_RETRY+1)`: failed attempts since last RUN; saturates at MAX_RETRY.

## Operation
- `locked` passes through a 2-flop synchronizer to form `locked_s`. All outputs are registered and decoded from the next state.
- Reset values: state RESET_DCM, counter 0, `dcm_reset`=1, `sys_reset`=1, `ready`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0.
- State machine:
  - **RESET_DCM:** `dcm_reset`=1. After RST_CYCLES cycles, go to WAIT_LOCK with the counter cleared.
  - **WAIT_LOCK:** `dcm_reset`=0.
    - If `locked_s`=1, go to SETTLE.
    - Else, when the counter reaches LOCK_TIMEOUT, the attempt fails.
  - **SETTLE:** when the counter reaches RELEASE_DLY with `locked_s` continuously high, go to RUN. If `locked_s` drops, the attempt fails.
  - **Failed attempt:**
    - If `retry_cnt`==MAX_RETRY, go to FAULT.
    - Else increment `retry_cnt` and go to RESET_DCM.
  - **RUN:** `sys_reset`=0 and `ready`=1; `retry_cnt` is cleared on entry. If `locked_s` falls, pulse `lock_lost` and go to RESET_DCM. `sys_reset`=1 on that same edge.
  - **FAULT:** `dcm_reset`=1, `sys_reset`=1, `fault`=1.
- `sys_reset` is 1 in every state except RUN.
- Simultaneous events: in WAIT_LOCK, lock and timeout on the same cycle resolve to SETTLE.
- Reset mid-operation: `reset_n` low forces the reset values asynchronously in any state. Sequencing restarts at RESET_DCM on the first edge after release.
- A single counter is shared by all states. Width is `$clog2` of the largest of RST_CYCLES, LOCK_TIMEOUT and RELEASE_DLY, plus 1. The counter clears on every state change.

## Timing
- After `reset_n` rises, `dcm_reset` stays high for exactly RST_CYCLES rising edges.
- Let `locked` be first sampled high at edge k. Then:
  - `locked_s` is high after edge k+1.
  - SETTLE is entered at edge k+2.
  - RUN is entered at edge k+2+RELEASE_DLY; `sys_reset`=0 from that edge.
- If WAIT_LOCK is entered at edge w with no lock, the failed transition happens at edge w+LOCK_TIMEOUT.
- Lock loss: `locked` falls at edge k. `lock_lost`=1 and `sys_reset`=1 after edge k+2, for one cycle.

## Configuration
- Macro: `DCM_SEQ_FAULT_REARM_EN`.
  - **Defined:** after LOCK_TIMEOUT cycles in FAULT, clear `retry_cnt` and `fault` and go to RESET_DCM.
  - **Undefined:** FAULT is terminal until `reset_n` is asserted.

## Structure
- Shared package `dcm_seq_pkg`: state encodings (RESET_DCM=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4) and the default parameter constants.
- One sub-module, `sync_2ff`: the `locked` synchronizer, reset to 0 by `reset_n`.

## Test plan
1. **Normal lock.** Release `reset_n`; `locked` rises 20 cycles after `dcm_reset` falls → `dcm_reset` high 8 cycles, `sys_reset` falls 18 edges after `locked` is first sampled, `ready`=1, `retry_cnt`=0.
2. **No lock.** LOCK_TIMEOUT=64 and `locked` tied 0 → 4 `dcm_reset` pulses, `retry_cnt` steps 1,2,3, then `fault`=1 and `sys_reset`=1 permanently. With the macro defined, a 5th pulse follows 64 cycles later with `retry_cnt`=0.
3. **Lock loss in RUN.** Drop `locked` while in RUN → `lock_lost` one-cycle pulse 2 edges later, `sys_reset`=1 on the same edge, `dcm_reset` high 8 cycles, RUN re-entered after relock.
4. **Glitch in SETTLE.** `locked` high 5 cycles then low → back to RESET_DCM, `retry_cnt`=1, `sys_reset` never deasserts.
5. **Reset mid-operation.** Assert `reset_n` mid-SETTLE → all outputs take reset values immediately, with no clock edge needed; full sequence repeats after release.
6. **Lock at timeout.** `locked_s` rises on the exact timeout edge → SETTLE entered, `retry_cnt` unchanged.
